// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Sequential instruction fetch with a valid/ack memory port and a
//            small prefetch FIFO in front of the IF/ID register.
//            Optional macro IF_FETCH_PERF_EN adds stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_addr;
    logic               r_outstanding;
    logic               r_squash;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_head_pc;
    logic [31:0]        r_head_instr;
    logic [31:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];

    logic               w_issue;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic [31:0]        w_resp_pc;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_CNT_W-1:0] w_cnt_after_pop;

    // Only a response to a request we actually hold counts; stray acks are ignored.
    assign w_resp          = r_outstanding & imem_ack;
    assign w_issue         = rst_n & ~r_outstanding & (r_count != c_FULL) & ~branch_taken;
    assign w_push          = w_resp & ~r_squash & ~branch_taken;
    assign w_valid         = (r_count != '0);
    assign w_pop           = w_valid & ~freeze & ~branch_taken;
    assign w_resp_pc       = r_req_addr + 32'd4;
    assign w_rd_ptr_nxt    = r_rd_ptr + c_PTR_W'(w_pop);
    assign w_cnt_after_pop = r_count - c_CNT_W'(w_pop);

    assign imem_req  = w_issue | (r_outstanding & ~imem_ack);
    assign imem_addr = w_issue ? r_fetch_pc : r_req_addr;
    assign valid_out = w_valid;
    assign pc_out    = r_head_pc;
    assign instr_out = r_head_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= 32'h0;
            r_outstanding <= 1'b0;
            r_squash      <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_head_pc     <= 32'h0;
            r_head_instr  <= 32'h0;
        end else begin
            if (w_issue) begin
                r_outstanding <= 1'b1;
                r_req_addr    <= r_fetch_pc;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end

            // A redirect while a request is in flight poisons that response.
            if (branch_taken && r_outstanding && !imem_ack) begin
                r_squash <= 1'b1;
            end else if (w_resp) begin
                r_squash <= 1'b0;
            end

            if (branch_taken) begin
                r_fetch_pc <= branch_addr;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= w_resp_pc;
                    r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
                end
                r_rd_ptr <= w_rd_ptr_nxt;
                r_count  <= w_cnt_after_pop + c_CNT_W'(w_push);

                // Head register: bypass into an empty FIFO, else follow the read pointer.
                if (w_push && (w_cnt_after_pop == '0)) begin
                    r_head_pc    <= w_resp_pc;
                    r_head_instr <= imem_rdata;
                end else if (w_pop && (w_cnt_after_pop != '0)) begin
                    r_head_pc    <= r_mem_pc[w_rd_ptr_nxt];
                    r_head_instr <= r_mem_instr[w_rd_ptr_nxt];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= w_resp_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (freeze && w_valid) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (branch_taken) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Directed vector bench for if_fetch_unit (default and wrap-PC builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    logic        rst2_n;
    logic        ack2;
    logic [31:0] rdata2;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        valid2;

    if_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out)
    );

    if_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk          (clk),
        .rst_n        (rst2_n),
        .freeze       (1'b0),
        .branch_taken (1'b0),
        .branch_addr  (32'h0),
        .imem_req     (req2),
        .imem_addr    (addr2),
        .imem_ack     (ack2),
        .imem_rdata   (rdata2),
        .pc_out       (pc2),
        .instr_out    (instr2),
        .valid_out    (valid2)
    );

    typedef struct {
        logic        freeze;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, " req"},   {31'h0, imem_req},  {31'h0, req});
        chk({tag, " addr"},  imem_addr,          addr);
        chk({tag, " valid"}, {31'h0, valid_out}, {31'h0, valid});
        chk({tag, " pc"},    pc_out,             pc);
        chk({tag, " instr"}, instr_out,          instr);
    endtask

    task automatic add(input logic f, input logic b, input logic [31:0] ba, input logic a,
                       input logic [31:0] rd, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.freeze = f;  v.br = b;  v.baddr = ba;  v.ack = a;  v.rdata = rd;
        v.e_req = er;  v.e_addr = ea;  v.e_valid = ev;  v.e_pc = ep;  v.e_instr = ei;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs settle by +1.
    task automatic cyc(input logic f, input logic b, input logic [31:0] ba,
                       input logic a, input logic [31:0] rd);
        @(negedge clk);
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_ack     = a;
        imem_rdata   = rd;
        #1;
    endtask

    task automatic cyc2(input logic a, input logic [31:0] rd);
        @(negedge clk);
        ack2   = a;
        rdata2 = rd;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        rst2_n = 1'b0; ack2 = 1'b0; rdata2 = 32'h0;

        // Sequential fetch (instr = ~addr), then a 10-cycle freeze filling the FIFO
        //   f  b  baddr  ack rdata          req addr         v  pc     instr
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h0,        0, 32'h0,  32'h0);
        add(0, 0, 32'h0, 1, 32'hFFFFFFFF,   0, 32'h0,        0, 32'h0,  32'h0);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h4,        1, 32'h4,  32'hFFFFFFFF);
        add(0, 0, 32'h0, 1, 32'hFFFFFFFB,   0, 32'h4,        0, 32'h4,  32'hFFFFFFFF);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h8,        1, 32'h8,  32'hFFFFFFFB);
        add(0, 0, 32'h0, 1, 32'hFFFFFFF7,   0, 32'h8,        0, 32'h8,  32'hFFFFFFFB);
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'hC,        1, 32'hC,  32'hFFFFFFF7);
        add(1, 0, 32'h0, 1, 32'hFFFFFFF3,   0, 32'hC,        1, 32'hC,  32'hFFFFFFF7);
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'h10,       1, 32'hC,  32'hFFFFFFF7);
        add(1, 0, 32'h0, 1, 32'hFFFFFFEF,   0, 32'h10,       1, 32'hC,  32'hFFFFFFF7);
        add(1, 0, 32'h0, 0, 32'h0,          1, 32'h14,       1, 32'hC,  32'hFFFFFFF7);
        add(1, 0, 32'h0, 1, 32'hFFFFFFEB,   0, 32'h14,       1, 32'hC,  32'hFFFFFFF7);
        for (int i = 0; i < 4; i++)
            add(1, 0, 32'h0, 0, 32'h0,      0, 32'h14,       1, 32'hC,  32'hFFFFFFF7);
        add(0, 0, 32'h0, 0, 32'h0,          0, 32'h14,       1, 32'hC,  32'hFFFFFFF7);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h18,       1, 32'h10, 32'hFFFFFFF3);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h18,       1, 32'h14, 32'hFFFFFFEF);
        add(0, 0, 32'h0, 1, 32'hFFFFFFE7,   0, 32'h18,       1, 32'h18, 32'hFFFFFFEB);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h1C,       1, 32'h1C, 32'hFFFFFFE7);
        add(0, 0, 32'h0, 0, 32'h0,          1, 32'h1C,       0, 32'h1C, 32'hFFFFFFE7);

        #1;
        chk("reset req",   {31'h0, imem_req},  32'h0);
        chk("reset addr",  imem_addr,          32'h0);
        chk("reset valid", {31'h0, valid_out}, 32'h0);
        chk("reset pc",    pc_out,             32'h0);
        chk("reset instr", instr_out,          32'h0);

        reset_dut();
        foreach (vecs[i]) begin
            cyc(vecs[i].freeze, vecs[i].br, vecs[i].baddr, vecs[i].ack, vecs[i].rdata);
            chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
        end

        // Redirect while the fetch of 0x20 is outstanding; its late ack is squashed.
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 32'h0, 0, 32'h0);
            cyc(0, 0, 32'h0, 1, ~(32'(k) * 32'd4));
        end
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("br pre", 1'b1, 32'h20, 1'b1, 32'h20, 32'hFFFFFFE3);
        cyc(0, 1, 32'h100, 0, 32'h0);
        chk_out("br cyc", 1'b1, 32'h20, 1'b0, 32'h20, 32'hFFFFFFE3);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("br wait1", 1'b1, 32'h20, 1'b0, 32'h20, 32'hFFFFFFE3);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("br wait2", 1'b1, 32'h20, 1'b0, 32'h20, 32'hFFFFFFE3);
        cyc(0, 0, 32'h0, 1, 32'hDEADBEEF);
        chk_out("br late ack", 1'b0, 32'h20, 1'b0, 32'h20, 32'hFFFFFFE3);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("br target req", 1'b1, 32'h100, 1'b0, 32'h20, 32'hFFFFFFE3);
        cyc(0, 0, 32'h0, 1, 32'h12345678);
        chk_out("br target ack", 1'b0, 32'h100, 1'b0, 32'h20, 32'hFFFFFFE3);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("br target head", 1'b1, 32'h104, 1'b1, 32'h104, 32'h12345678);

        // Redirect in the same cycle as the ack: the word is dropped.
        cyc(0, 1, 32'h40, 1, 32'hBAD0BAD0);
        chk_out("brack cyc", 1'b0, 32'h104, 1'b0, 32'h104, 32'h12345678);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("brack req", 1'b1, 32'h40, 1'b0, 32'h104, 32'h12345678);
        cyc(0, 0, 32'h0, 1, 32'h40404040);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("brack head", 1'b1, 32'h44, 1'b1, 32'h44, 32'h40404040);

        // Back-to-back redirects: the last target wins.
        cyc(0, 1, 32'h200, 0, 32'h0);
        cyc(0, 1, 32'h300, 0, 32'h0);
        chk_out("b2b hold", 1'b1, 32'h44, 1'b0, 32'h44, 32'h40404040);
        cyc(0, 0, 32'h0, 1, 32'h55555555);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("b2b req", 1'b1, 32'h300, 1'b0, 32'h44, 32'h40404040);
        cyc(0, 0, 32'h0, 1, 32'h33333333);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("b2b head", 1'b1, 32'h304, 1'b1, 32'h304, 32'h33333333);

        // Reset in the middle of an outstanding request, then a stray ack.
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk({"midrst pre req"}, {31'h0, imem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 0, 32'h0, 1, 32'hFFFF0000);
        chk_out("stray ack", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("stray ignored", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        cyc(0, 0, 32'h0, 1, 32'hCAFEF00D);
        cyc(0, 0, 32'h0, 0, 32'h0);
        chk_out("post rst head", 1'b1, 32'h4, 1'b1, 32'h4, 32'hCAFEF00D);

        // Address wrap from RESET_PC = 0xFFFFFFFC.
        @(posedge clk);
        #1 rst2_n = 1'b1;
        cyc2(0, 32'h0);
        chk("wrap req1",   addr2,          32'hFFFFFFFC);
        chk("wrap req1 v", {31'h0, req2},  32'h1);
        cyc2(1, 32'h11111111);
        cyc2(0, 32'h0);
        chk("wrap req2",   addr2,          32'h0);
        chk("wrap head1 pc",    pc2,       32'h0);
        chk("wrap head1 instr", instr2,    32'h11111111);
        chk("wrap head1 valid", {31'h0, valid2}, 32'h1);
        cyc2(1, 32'h22222222);
        cyc2(0, 32'h0);
        chk("wrap head2 pc",    pc2,       32'h4);
        chk("wrap head2 instr", instr2,    32'h22222222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
